// File: rtl/inst_enc_pkg.sv
// Shared types, opcodes and the immediate range check for the RV32I instruction encoder.
package inst_enc_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [2:0] {
        FMT_LOAD   = 3'd0,
        FMT_STORE  = 3'd1,
        FMT_BRANCH = 3'd2,
        FMT_ALU_I  = 3'd3,
        FMT_JAL    = 3'd4
    } fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_ALU_I  = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

    typedef struct packed {
        logic [2:0]        fmt;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [2:0]        funct3;
        logic [INST_W-1:0] imm;
    } enc_req_t;

    // True when imm is representable in the immediate field of fmt.
    function automatic logic imm_ok(input logic [2:0] fmt, input logic [INST_W-1:0] imm);
        logic ok;
        case (fmt)
            FMT_LOAD, FMT_STORE, FMT_ALU_I: ok = (&imm[31:11]) || !(|imm[31:11]);
            FMT_BRANCH: ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
            FMT_JAL:    ok = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational range check and bit scatter of one request into an RV32I word.
module inst_pack
    import inst_enc_pkg::*;
(
    input  logic [2:0]        fmt,
    input  logic [REG_W-1:0]  rd,
    input  logic [REG_W-1:0]  rs1,
    input  logic [REG_W-1:0]  rs2,
    input  logic [2:0]        funct3,
    input  logic [INST_W-1:0] imm,
    output logic [INST_W-1:0] inst_c,
    output logic              err_c
);

    logic [INST_W-1:0] raw;

    always_comb begin
        raw   = '0;
        err_c = !imm_ok(fmt, imm);
        case (fmt)
            FMT_LOAD:   raw = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            FMT_ALU_I:  raw = {imm[11:0], rs1, funct3, rd, OPC_ALU_I};
            FMT_STORE:  raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            FMT_BRANCH: raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
            FMT_JAL:    raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            default:    raw = NOP_INST;
        endcase
        inst_c = err_c ? NOP_INST : raw;
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready instruction encoder: S1 holds the request, S2 the packed word and address.
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [INST_W-1:0] in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic              s1_valid_q, s1_valid_d;
    enc_req_t          s1_req_q, s1_req_d;
    logic              s1_err_q, s1_err_d;
    logic              s2_valid_q, s2_valid_d;
    logic [INST_W-1:0] s2_inst_q, s2_inst_d;
    logic              s2_err_q, s2_err_d;
    logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;

    logic              s2_free, s1_adv, in_fire, out_fire;
    logic [INST_W-1:0] pack_inst;
    logic              pack_err;

    inst_pack u_pack (
        .fmt    (s1_req_q.fmt),
        .rd     (s1_req_q.rd),
        .rs1    (s1_req_q.rs1),
        .rs2    (s1_req_q.rs2),
        .funct3 (s1_req_q.funct3),
        .imm    (s1_req_q.imm),
        .inst_c (pack_inst),
        .err_c  (pack_err)
    );

    // Handshake and next-state for both stages, the address and the error counter.
    always_comb begin
        s2_free  = !s2_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_free;
        in_ready = !reset && (!s1_valid_q || s2_free);
        in_fire  = in_valid && in_ready;
        out_fire = s2_valid_q && out_ready;

        s1_valid_d  = s1_valid_q;
        s1_req_d    = s1_req_q;
        s1_err_d    = s1_err_q;
        s2_valid_d  = s2_valid_q;
        s2_inst_d   = s2_inst_q;
        s2_err_d    = s2_err_q;
        s2_addr_d   = s2_addr_q;
        next_addr_d = next_addr_q;
        err_count_d = err_count_q;

        if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_req_d   = '{fmt: in_fmt, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                           funct3: in_funct3, imm: in_imm};
            s1_err_d   = !imm_ok(in_fmt, in_imm);
        end

        if (out_fire) begin
            s2_valid_d = 1'b0;
            if (s2_err_q && err_count_q != CNT_MAX) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end
        if (s1_adv) begin
            s2_valid_d  = 1'b1;
            s2_err_d    = s1_err_q || pack_err;
            s2_inst_d   = s2_err_d ? NOP_INST : pack_inst;
            s2_addr_d   = next_addr_q;
            next_addr_d = next_addr_q + ADDR_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_req_q    <= '0;
            s1_err_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_inst_q   <= '0;
            s2_err_q    <= 1'b0;
            s2_addr_q   <= ADDR_BASE;
            next_addr_q <= ADDR_BASE;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_req_q    <= s1_req_d;
            s1_err_q    <= s1_err_d;
            s2_valid_q  <= s2_valid_d;
            s2_inst_q   <= s2_inst_d;
            s2_err_q    <= s2_err_d;
            s2_addr_q   <= s2_addr_d;
            next_addr_q <= next_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_inst  = s2_inst_q;
    assign out_err   = s2_err_q;
    assign out_addr  = s2_addr_q;
    assign err_count = err_count_q;

endmodule
